// File: rtl/id_stage_day16.sv
// Instruction-decode stage: IF/ID register, 16x8 register file with write-back
// bypass, opcode decode, load-use hazard detection and the ID/EX register.
module id_stage_day16 (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  if_pc,
  input  logic [19:0] if_instr,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [3:0]  wb_rd,
  input  logic [7:0]  wb_data,
  output logic        pc_write,
  output logic        ex_valid,
  output logic [7:0]  ex_pc,
  output logic [3:0]  ex_opcode,
  output logic [3:0]  ex_rd,
  output logic [3:0]  ex_rs1,
  output logic [3:0]  ex_rs2,
  output logic [7:0]  ex_a,
  output logic [7:0]  ex_b,
  output logic [7:0]  ex_imm,
  output logic        ex_reg_write,
  output logic        ex_mem_read
);

  typedef struct packed {
    logic       valid;
    logic [7:0] pc;
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic       reg_write;
    logic       mem_read;
  } idex_t;

  logic        id_valid_q, id_valid_d;
  logic [7:0]  id_pc_q, id_pc_d;
  logic [19:0] id_instr_q, id_instr_d;
  logic [7:0]  rf_q [16];
  logic [7:0]  rf_d [16];
  idex_t       ex_q, ex_d;

  logic [3:0]  id_op, id_rd, id_rs1, id_rs2;
  logic [7:0]  id_imm, rd_a, rd_b;
  logic        uses_rs1, uses_rs2, writes_rd, reads_mem;
  logic        stall;

  // r0 is hard-wired to zero; a same-cycle write-back is forwarded to the reader.
  function automatic logic [7:0] read_port(input logic [3:0] rs, input logic [7:0] stored,
                                           input logic we, input logic [3:0] wrd,
                                           input logic [7:0] wdata);
    if (rs == 4'd0)             return 8'd0;
    else if (we && (wrd == rs)) return wdata;
    else                        return stored;
  endfunction

  assign id_op  = id_instr_q[19:16];
  assign id_rd  = id_instr_q[15:12];
  assign id_rs1 = id_instr_q[11:8];
  assign id_rs2 = id_instr_q[7:4];
  assign id_imm = id_instr_q[7:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    reads_mem = 1'b0;
    case (id_op) inside
      [4'h1:4'h7]: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      4'h8:        begin uses_rs1 = 1'b1; writes_rd = 1'b1; reads_mem = 1'b1; end
      4'h9:        begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      4'hA:        begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      4'hB:        begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      default:     ;
    endcase
  end

  assign rd_a = read_port(id_rs1, rf_q[id_rs1], wb_we, wb_rd, wb_data);
  assign rd_b = read_port(id_rs2, rf_q[id_rs2], wb_we, wb_rd, wb_data);

  assign stall = ex_q.valid & ex_q.mem_read & (ex_q.rd != 4'd0) & id_valid_q &
                 ((uses_rs1 & (ex_q.rd == id_rs1)) | (uses_rs2 & (ex_q.rd == id_rs2)));

  assign pc_write = ~stall | flush;

  always_comb begin
    rf_d = rf_q;
    if (wb_we && (wb_rd != 4'd0)) rf_d[wb_rd] = wb_data;
  end

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    ex_d       = '0;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (!stall) begin
      id_valid_d = 1'b1;
      id_pc_d    = if_pc;
      id_instr_d = if_instr;
      ex_d.valid     = id_valid_q;
      ex_d.pc        = id_pc_q;
      ex_d.opcode    = id_op;
      ex_d.rd        = id_rd;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.a         = rd_a;
      ex_d.b         = rd_b;
      ex_d.imm       = id_imm;
      ex_d.reg_write = writes_rd & id_valid_q;
      ex_d.mem_read  = reads_mem & id_valid_q;
    end
    // A stall leaves IF/ID untouched and sends the all-zero bubble to EX.
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  // NOTE: the register file is reset like any other flop because software
  // relies on every register reading zero after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      rf_q       <= '{default: '0};
      ex_q       <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      rf_q       <= rf_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_opcode    = ex_q.opcode;
  assign ex_rd        = ex_q.rd;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_a         = ex_q.a;
  assign ex_b         = ex_q.b;
  assign ex_imm       = ex_q.imm;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;

endmodule

// File: doc/id_stage_day16.md
ID_STAGE_DAY16 -- requirements
Module: id_stage_day16

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-003 SHALL have port if_pc  input  8  PC of the instruction presented by fetch.
REQ-004 SHALL have port if_instr  input  20  fetched instruction: opcode[19:16], rd[15:12], rs1[11:8], rs2[7:4], imm8[7:0].
REQ-005 SHALL have port flush  input  1  taken-branch kill from EX.
REQ-006 SHALL have ports wb_we  input  1, wb_rd  input  4, wb_data  input  8  register-file write-back port.
REQ-007 SHALL have port pc_write  output  1  fetch PC advance enable; combinational.
REQ-008 SHALL have ports ex_valid 1, ex_pc 8, ex_opcode 4, ex_rd 4, ex_rs1 4, ex_rs2 4, ex_a 8, ex_b 8, ex_imm 8, ex_reg_write 1, ex_mem_read 1, all outputs, all registered (ID/EX register).

Function
REQ-009 SHALL hold an IF/ID register {id_valid, id_pc, id_instr}.
- Loads {1, if_pc, if_instr} each cycle pc_write=1 and flush=0.
- Holds while pc_write=0 and flush=0.
REQ-010 SHALL hold a 16x8 register file.
- Write at clock edge when wb_we=1 and wb_rd!=0.
- r0 always reads 0; writes to r0 are ignored.
REQ-011 SHALL bypass register-file reads: a read of the register being written this cycle (wb_we=1, wb_rd=rs, rs!=0) returns wb_data.
REQ-012 SHALL decode opcodes as follows.
- 0 = NOP.
- 1-7 = ALU reg-reg: uses rs1 and rs2, writes rd.
- 8 = LOAD: uses rs1, writes rd, mem_read=1.
- 9 = STORE: uses rs1 and rs2.
- A = ADDI: uses rs1, writes rd.
- B = BEQ: uses rs1 and rs2.
- C-F = treated as NOP.
REQ-013 SHALL compute the load-use stall as: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
REQ-014 SHALL drive pc_write = !stall | flush.
REQ-015 SHALL, on a stall without flush, load a bubble into ID/EX and keep IF/ID unchanged.
- Bubble = ex_valid=0, ex_reg_write=0, ex_mem_read=0.
- Stall lasts exactly 1 cycle per load-use pair.
REQ-016 SHALL, on flush, load a bubble into ID/EX and clear id_valid at the same edge. Flush takes priority over stall.
REQ-017 SHALL otherwise load ID/EX from the decoded IF/ID contents.
- ex_valid = id_valid.
- ex_a / ex_b = regfile[rs1] / regfile[rs2] after bypass.
- ex_imm = imm8.
- ex_reg_write and ex_mem_read gated by id_valid.
REQ-018 SHALL have a latency of 2 edges from if_instr sampled to ex_* valid when no stall or flush occurs.
REQ-019 SHALL, for an invalid IF/ID entry, produce a bubble and never raise a stall.

Reset
REQ-020 SHALL, on rstn=0, immediately and asynchronously clear id_valid, id_pc, id_instr, all 16 registers, and all ex_* outputs to 0.
REQ-021 SHALL drive pc_write=1 during and after reset, because no stall condition can exist.
REQ-022 SHALL, if reset is asserted mid-stall, discard the stalled instruction; the first post-reset edge captures if_instr normally.

Verification
REQ-023 SHALL pass: reset, then if_pc=0, if_instr=0x1_3_1_2_0 (ADD r3,r1,r2) with r1=5, r2=7 preloaded via wb -> after 2 edges ex_valid=1, ex_opcode=1, ex_rd=3, ex_a=5, ex_b=7, ex_reg_write=1.
REQ-024 SHALL pass: LOAD r4,r1 followed by ADD r5,r4,r2 -> pc_write=0 for exactly 1 cycle; ID/EX shows a bubble; ADD reaches EX one cycle later with unchanged fields.
REQ-025 SHALL pass: LOAD r0 followed by an instruction using r0, and LOAD r4 followed by ADDI r6,r1 -> no stall (pc_write stays 1).
REQ-026 SHALL pass: flush=1 coincident with a load-use stall -> pc_write=1, next cycle ex_valid=0 and id_valid=0.
REQ-027 SHALL pass: wb_we=1, wb_rd=2, wb_data=0xAA in the same cycle ID reads r2 -> ex_b=0xAA; wb_rd=0, wb_data=0xFF -> r0 still reads 0.
REQ-028 SHALL pass: rstn pulsed low between clock edges with the pipe full -> all ex_* outputs are 0 immediately, before the next edge.
